// File: rtl/counter_seq_pkg.sv
// Shared definitions for the 4-bit up/down wrap counter sequence
// (0,1,2,3,15,14,13,12,0,...). The generator and the checker both use these.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } seq_state_e;

  // Turning points of the sequence
  localparam logic [3:0] SEQ_UP_TOP = 4'd3;
  localparam logic [3:0] SEQ_DN_TOP = 4'd15;
  localparam logic [3:0] SEQ_DN_BOT = 4'd12;

  // A value belongs to the sequence if it is in the up run (0..3)
  // or the down run (12..15); 4..11 never occur.
  function automatic logic seq_legal(input logic [3:0] v);
    return (v <= SEQ_UP_TOP) || (v >= SEQ_DN_BOT);
  endfunction

endpackage

// File: rtl/counter_seq_next.sv
// Combinational successor of a sequence value plus its legality flag.
// For illegal inputs the successor is 0 and must be ignored by the user.
module counter_seq_next
  import counter_seq_pkg::*;
(
  input  logic [3:0] v,
  output logic [3:0] nxt,
  output logic       legal
);

  // Successor function: count up to the top of the up run, jump to 15,
  // count down to the bottom of the down run, then wrap to 0.
  always_comb begin
    nxt   = 4'd0;
    legal = seq_legal(v);
    if (v < SEQ_UP_TOP) begin
      nxt = v + 4'd1;
    end else if (v == SEQ_UP_TOP) begin
      nxt = SEQ_DN_TOP;
    end else if (v > SEQ_DN_BOT) begin
      nxt = v - 4'd1;
    end else begin
      nxt = 4'd0;
    end
  end

endmodule

// File: rtl/counter_seq_checker.sv
// Receive-side checker for the 4-bit up/down wrap counter.
// Hunts for a legal value, confirms LOCK_MATCHES consecutive correct samples,
// then tracks the sequence with a flywheel and flags mismatches.
//
// Handshake: q_valid qualifies q_in for the current rising edge only; there is
// no back-pressure, every edge with q_valid=1 consumes exactly one sample and
// edges with q_valid=0 leave all state untouched (err returns to 0).
module counter_seq_checker
  import counter_seq_pkg::*;
#(
  parameter int LOCK_MATCHES = 4,
  parameter int MISS_LIMIT   = 2,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           q_in,
  input  logic                 q_valid,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [3:0]           expected,
  output seq_state_e           state_dbg
);

  localparam int RUN_W  = $clog2(LOCK_MATCHES + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  seq_state_e          state;
  logic [RUN_W-1:0]    run_cnt;
  logic [MISS_W-1:0]   miss_cnt;

  logic [3:0]          q_nxt;
  logic                q_legal;
  logic [3:0]          exp_nxt;
  logic                exp_legal;

  logic                match;
  logic [RUN_W-1:0]    run_inc;
  logic [MISS_W-1:0]   miss_inc;
  logic                lock_miss;

  // Successor of the incoming sample (used to seed/re-seed the prediction)
  counter_seq_next u_next_q (
    .v     (q_in),
    .nxt   (q_nxt),
    .legal (q_legal)
  );

  // Successor of the current prediction (flywheel advance)
  counter_seq_next u_next_exp (
    .v     (expected),
    .nxt   (exp_nxt),
    .legal (exp_legal)
  );

  // Sample comparison and counter increments shared by the FSM and err_cnt
  always_comb begin
    match     = (q_in == expected) && exp_legal;
    run_inc   = run_cnt + RUN_W'(1);
    miss_inc  = miss_cnt + MISS_W'(1);
    lock_miss = q_valid && (state == LOCKED) && !match;
  end

  assign state_dbg = state;

  // Lock FSM: HUNT -> CONFIRM -> LOCKED, with registered locked/err/expected
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= HUNT;
      locked   <= 1'b0;
      err      <= 1'b0;
      expected <= 4'd0;
      run_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      err <= 1'b0;
      if (q_valid) begin
        case (state)
          HUNT: begin
            if (q_legal) begin
              expected <= q_nxt;
              run_cnt  <= RUN_W'(1);
              if (LOCK_MATCHES == 1) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end else begin
                state <= CONFIRM;
              end
            end
          end
          CONFIRM: begin
            if (match) begin
              run_cnt  <= run_inc;
              expected <= exp_nxt;
              if (run_inc == RUN_W'(LOCK_MATCHES)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else if (q_legal) begin
              // Re-seed on the new value rather than waiting in HUNT
              expected <= q_nxt;
              run_cnt  <= RUN_W'(1);
            end else begin
              state   <= HUNT;
              run_cnt <= '0;
            end
          end
          LOCKED: begin
            // Prediction always advances from itself: one bad sample
            // must not pull the phase away from the real counter.
            expected <= exp_nxt;
            if (match) begin
              miss_cnt <= '0;
            end else begin
              err <= 1'b1;
              if (miss_inc == MISS_W'(MISS_LIMIT)) begin
                state    <= HUNT;
                locked   <= 1'b0;
                miss_cnt <= '0;
                run_cnt  <= '0;
              end else begin
                miss_cnt <= miss_inc;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating error counter; a clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (lock_miss && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker. Two instances share the stimulus:
// dut uses the default 8-bit err_cnt, dut_w2 a 2-bit err_cnt for saturation.
module tb_counter_seq_checker;
  import counter_seq_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] q_in;
  logic       q_valid;
  logic       clr_cnt;

  logic       locked,  locked2;
  logic       err,     err2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  logic [3:0] expected, expected2;
  seq_state_e st, st2;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  counter_seq_checker dut (
    .clk       (clk),
    .reset     (reset),
    .q_in      (q_in),
    .q_valid   (q_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt),
    .expected  (expected),
    .state_dbg (st)
  );

  counter_seq_checker #(.ERR_CNT_W(2)) dut_w2 (
    .clk       (clk),
    .reset     (reset),
    .q_in      (q_in),
    .q_valid   (q_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked2),
    .err       (err2),
    .err_cnt   (err_cnt2),
    .expected  (expected2),
    .state_dbg (st2)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Present one valid sample for one edge, then leave outputs settled
  task automatic drive(input logic [3:0] v, input logic clr);
    @(negedge clk);
    q_in    = v;
    q_valid = 1'b1;
    clr_cnt = clr;
    @(posedge clk);
    #1;
    q_valid = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic send(input logic [3:0] v);
    drive(v, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_cnt();
    @(negedge clk);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    q_in    = 4'd0;
    q_valid = 1'b0;
    clr_cnt = 1'b0;
    #12;
    check("rst_locked",   locked,   0);
    check("rst_err",      err,      0);
    check("rst_err_cnt",  err_cnt,  0);
    check("rst_expected", expected, 0);
    check("rst_state",    st,       HUNT);
    @(negedge clk);
    reset = 1'b1;

    // HUNT ignores illegal values; CONFIRM re-seeds on legal, drops on illegal
    send(4'd7);
    check("hunt_illegal_state", st, HUNT);
    send(4'd0);
    check("hunt_seed_state", st, CONFIRM);
    check("hunt_seed_exp", expected, 1);
    send(4'd13);
    check("confirm_reseed_state", st, CONFIRM);
    check("confirm_reseed_exp", expected, 12);
    send(4'd9);
    check("confirm_illegal_state", st, HUNT);

    // Acquire lock on 0,1,2,3
    send(4'd0);
    send(4'd1);
    send(4'd2);
    check("acq_not_locked", locked, 0);
    check("acq_err", err, 0);
    send(4'd3);
    check("acq_locked", locked, 1);
    check("acq_exp15", expected, 15);
    check("acq_state", st, LOCKED);
    check("acq_no_err", err, 0);

    // Run through both wrap points: 3->15 and 12->0
    exp_q = '{32'd14, 32'd13, 32'd12, 32'd0, 32'd1, 32'd2};
    foreach (exp_q[i]) begin end
    begin
      logic [3:0] seq[6];
      seq = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd0, 4'd1};
      for (int i = 0; i < 6; i++) begin
        send(seq[i]);
        check("wrap_exp", expected, exp_q.pop_front());
        check("wrap_err", err, 0);
      end
    end
    check("wrap_locked", locked, 1);

    // Bring expected to 14, then one bad sample followed by a flywheel match
    send(4'd2);
    send(4'd3);
    send(4'd15);
    check("pre_fly_exp", expected, 14);
    send(4'd9);
    check("fly_err", err, 1);
    check("fly_err_cnt", err_cnt, 1);
    check("fly_locked", locked, 1);
    check("fly_exp", expected, 13);
    send(4'd13);
    check("fly_match_err", err, 0);
    check("fly_match_locked", locked, 1);
    check("fly_match_exp", expected, 12);

    // Two consecutive misses drop lock
    clear_cnt();
    check("clr_idle", err_cnt, 0);
    send(4'd5);
    check("miss1_err", err, 1);
    check("miss1_locked", locked, 1);
    send(4'd6);
    check("miss2_err", err, 1);
    check("miss2_err_cnt", err_cnt, 2);
    check("miss2_locked", locked, 0);
    check("miss2_state", st, HUNT);

    // Relock on 2,3,15,14 with a q_valid gap inside the run
    send(4'd2);
    idle(3);
    check("gap_state", st, CONFIRM);
    check("gap_exp", expected, 3);
    check("gap_err", err, 0);
    send(4'd3);
    send(4'd15);
    check("relock_pending", locked, 0);
    send(4'd14);
    check("relock_locked", locked, 1);
    check("relock_exp", expected, 13);

    // Five locked errors interleaved with matches (includes 15 then 0)
    clear_cnt();
    send(4'd0);   // err 1, exp 12
    send(4'd12);  // match, exp 0
    send(4'd7);   // err 2, exp 1
    send(4'd1);   // match, exp 2
    send(4'd0);   // err 3, exp 3
    send(4'd3);   // match, exp 15
    send(4'd15);  // match, exp 14
    send(4'd0);   // err 4, exp 13
    check("sat4_w2", err_cnt2, 3);
    check("sat4_w8", err_cnt, 4);
    send(4'd13);  // match, exp 12
    send(4'd5);   // err 5, exp 0
    check("sat5_w2", err_cnt2, 3);
    check("sat5_w8", err_cnt, 5);
    check("sat5_locked", locked2, 1);
    send(4'd0);   // match, exp 1
    drive(4'd7, 1'b1);
    check("clr_err_w2", err2, 1);
    check("clr_cnt_w2", err_cnt2, 0);
    check("clr_cnt_w8", err_cnt, 0);
    check("clr_locked", locked, 1);
    check("clr_exp", expected, 2);

    // Build err_cnt=3 then reset mid-sequence
    send(4'd2);   // match, exp 3
    send(4'd9);   // err, exp 15
    send(4'd15);  // match, exp 14
    send(4'd9);   // err, exp 13
    send(4'd13);  // match, exp 12
    send(4'd9);   // err, exp 0
    check("pre_rst_cnt", err_cnt2, 3);
    check("pre_rst_err", err, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_locked", locked, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_cnt", err_cnt, 0);
    check("mid_rst_cnt_w2", err_cnt2, 0);
    check("mid_rst_exp", expected, 0);
    check("mid_rst_state", st, HUNT);
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    check("post_rst_state", st, HUNT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
